cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto one RAM port. Build with ARB_FAIR_EN to alternate
// grants under contention; without it the dcache always wins.
module cache_mem_arbiter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN_i,
  input  logic [31:0] iaddr_i,
  output logic        iwait_o,
  output logic [31:0] iload_o,
  input  logic        dREN_i,
  input  logic        dWEN_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dstore_i,
  output logic        dwait_o,
  output logic [31:0] dload_o,
  output logic        ramREN_o,
  output logic        ramWEN_o,
  output logic [31:0] ramaddr_o,
  output logic [31:0] ramstore_o,
  input  logic [31:0] ramload_i,
  input  logic [1:0]  ramstate_i
);

  typedef logic [31:0] word_t;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {StIdle, StIgnt, StDgnt} state_e;

  state_e state_q, state_d;
  word_t  iaddr_q, iaddr_d;
  word_t  daddr_q, daddr_d;
  word_t  dstore_q, dstore_d;
  logic   dwen_q, dwen_d;
  logic   d_req;
  logic   i_first;

  assign d_req = dREN_i | dWEN_i;

`ifdef ARB_FAIR_EN
  logic last_d_q, last_d_d;

  // Under contention the icache goes first only if the dcache won last time.
  assign i_first = iREN_i & last_d_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign i_first = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dstore_q <= '0;
      dwen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      dstore_q <= dstore_d;
      dwen_q   <= dwen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iaddr_d    = iaddr_q;
    daddr_d    = daddr_q;
    dstore_d   = dstore_q;
    dwen_d     = dwen_q;
    ramREN_o   = 1'b0;
    ramWEN_o   = 1'b0;
    ramaddr_o  = '0;
    ramstore_o = '0;
    iwait_o    = 1'b1;
    iload_o    = '0;
    dwait_o    = 1'b1;
    dload_o    = '0;
`ifdef ARB_FAIR_EN
    last_d_d   = last_d_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (d_req && !i_first) begin
          state_d  = StDgnt;
          daddr_d  = daddr_i;
          dstore_d = dstore_i;
          dwen_d   = dWEN_i;
        end else if (iREN_i) begin
          state_d = StIgnt;
          iaddr_d = iaddr_i;
        end
      end
      StIgnt: begin
        ramREN_o  = 1'b1;
        ramaddr_o = iaddr_q;
        // A dropped request is an abort and wins over a simultaneous RAM response.
        if (!iREN_i) begin
          state_d = StIdle;
        end else if (ramstate_i == RamAccess) begin
          iwait_o = 1'b0;
          iload_o = ramload_i;
          state_d = StIdle;
`ifdef ARB_FAIR_EN
          last_d_d = 1'b0;
`endif
        end else if (ramstate_i == RamError) begin
          state_d = StIdle;
        end
      end
      StDgnt: begin
        ramREN_o   = ~dwen_q;
        ramWEN_o   = dwen_q;
        ramaddr_o  = daddr_q;
        ramstore_o = dstore_q;
        if (!d_req) begin
          state_d = StIdle;
        end else if (ramstate_i == RamAccess) begin
          dwait_o = 1'b0;
          dload_o = ramload_i;
          state_d = StIdle;
`ifdef ARB_FAIR_EN
          last_d_d = 1'b1;
`endif
        end else if (ramstate_i == RamError) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
